// File: rtl/gpu_pkg.sv
// gpu_pkg: shared opcode encoding, instruction field positions and sequencer state type.
package gpu_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int OPC_LSB = 12;
    localparam int RD_LSB = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;
    localparam int IMM_LSB = 0;
    // Values double as the ALU's alu_control encoding.
    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_LDI = 4'h6,
        OP_NOP = 4'h7
    } opcode_t;
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
    function automatic logic is_alu(logic [3:0] op);
        return op <= OP_XOR;
    endfunction
endpackage

// File: rtl/thread_alu_sequencer_if.sv
// thread_alu_sequencer_if: instruction handshake plus ALU operand/result bus.
interface thread_alu_sequencer_if #(parameter int DATA_WIDTH = 16);
    logic                  instr_valid;
    logic [15:0]           instr;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [3:0]            alu_control;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    modport master (
        input  instr_valid, instr, alu_result, alu_zero,
        output instr_ready, alu_a, alu_b, alu_control
    );
    modport slave (
        output instr_valid, instr, alu_result, alu_zero,
        input  instr_ready, alu_a, alu_b, alu_control
    );
endinterface

// File: rtl/thread_regfile.sv
// thread_regfile: two combinational read ports, one debug read, one sync write; R0 reads zero.
module thread_regfile #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int AW         = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         ra1,
    input  logic [AW-1:0]         ra2,
    input  logic [AW-1:0]         dbg_addr,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end
    assign rd1      = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2      = (ra2 == '0) ? '0 : regs[ra2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
endmodule

// File: rtl/thread_alu_sequencer.sv
// thread_alu_sequencer: runs one instruction at a time through READ/EXEC/WB against an external ALU.
module thread_alu_sequencer
    import gpu_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = gpu_pkg::DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    thread_alu_sequencer_if.master        bus,
    output logic                          done,
    output logic                          illegal,
    output logic                          zero_flag,
    input  logic [3:0]                    dbg_addr,
    output logic [DATA_WIDTH-1:0]         dbg_data
);
    localparam int AW = $clog2(NUM_REGS);
    state_t                state;
    logic [15:0]           ir;
    logic [DATA_WIDTH-1:0] res;
    logic                  zcap;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [3:0]            op;
    logic                  we;
    logic [DATA_WIDTH-1:0] wd;
    assign op = ir[OPC_LSB +: 4];
    assign we = (state == WB) && (is_alu(op) || op == OP_LDI);
    assign wd = (op == OP_LDI) ? DATA_WIDTH'(ir[IMM_LSB +: 8]) : res;
    thread_regfile #(.NUM_REGS(NUM_REGS), .DATA_WIDTH(DATA_WIDTH)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .ra1      (ir[RS1_LSB +: AW]),
        .ra2      (ir[RS2_LSB +: AW]),
        .dbg_addr (dbg_addr[AW-1:0]),
        .we       (we),
        .wa       (ir[RD_LSB +: AW]),
        .wd       (wd),
        .rd1      (rd1),
        .rd2      (rd2),
        .dbg_data (dbg_data)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            ir              <= '0;
            res             <= '0;
            zcap            <= 1'b0;
            bus.instr_ready <= 1'b1;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_control <= '0;
            done            <= 1'b0;
            illegal         <= 1'b0;
            zero_flag       <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: if (bus.instr_valid) begin
                    ir              <= bus.instr;
                    bus.instr_ready <= 1'b0;
                    state           <= READ;
                end
                READ: begin
                    bus.alu_a       <= rd1;
                    bus.alu_b       <= rd2;
                    bus.alu_control <= op;
                    state           <= EXEC;
                end
                EXEC: begin
                    res   <= bus.alu_result;
                    zcap  <= bus.alu_zero;
                    state <= WB;
                end
                default: begin
                    if (is_alu(op)) zero_flag <= zcap;
                    done            <= 1'b1;
                    illegal         <= op[3];
                    bus.instr_ready <= 1'b1;
                    state           <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_thread_alu_sequencer.sv
// tb_thread_alu_sequencer: directed vector table plus hand sequences for busy-hold and mid-op reset.
module tb_thread_alu_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        done;
    logic        illegal;
    logic        zero_flag;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
    int          total = 0;
    int          bad = 0;
    thread_alu_sequencer_if #(.DATA_WIDTH(16)) bus ();
    thread_alu_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .done      (done),
        .illegal   (illegal),
        .zero_flag (zero_flag),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );
    always #5 clk = ~clk;
    // Reference ALU the sequencer drives.
    always_comb begin
        case (bus.alu_control)
            4'h0:    bus.alu_result = bus.alu_a + bus.alu_b;
            4'h1:    bus.alu_result = bus.alu_a - bus.alu_b;
            4'h2:    bus.alu_result = bus.alu_a * bus.alu_b;
            4'h3:    bus.alu_result = bus.alu_a & bus.alu_b;
            4'h4:    bus.alu_result = bus.alu_a | bus.alu_b;
            4'h5:    bus.alu_result = bus.alu_a ^ bus.alu_b;
            default: bus.alu_result = 16'h0000;
        endcase
        bus.alu_zero = (bus.alu_result == 16'h0000);
    end
    typedef struct {
        logic [15:0] w;
        logic [3:0]  reg_idx;
        logic [15:0] reg_val;
        logic        z;
        logic        ill;
    } vec_t;
    vec_t vecs [17];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask
    task automatic run(input logic [15:0] w, output int lat, output logic ill);
        bus.instr_valid = 1'b1;
        bus.instr = w;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr = 16'hA5A5;
        lat = 0;
        ill = 1'b0;
        while (lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                ill = illegal;
                break;
            end
        end
    endtask
    initial begin
        int          lat;
        int          acc;
        logic        ill;
        logic [15:0] d;
        vecs[0]  = '{16'h6105, 4'd1,  16'h0005, 1'b0, 1'b0};
        vecs[1]  = '{16'h6203, 4'd2,  16'h0003, 1'b0, 1'b0};
        vecs[2]  = '{16'h0312, 4'd3,  16'h0008, 1'b0, 1'b0};
        vecs[3]  = '{16'h1411, 4'd4,  16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{16'h5512, 4'd5,  16'h0006, 1'b0, 1'b0};
        vecs[5]  = '{16'h61FF, 4'd1,  16'h00FF, 1'b0, 1'b0};
        vecs[6]  = '{16'h2611, 4'd6,  16'hFE01, 1'b0, 1'b0};
        vecs[7]  = '{16'h6101, 4'd1,  16'h0001, 1'b0, 1'b0};
        vecs[8]  = '{16'h1101, 4'd1,  16'hFFFF, 1'b0, 1'b0};
        vecs[9]  = '{16'h6201, 4'd2,  16'h0001, 1'b0, 1'b0};
        vecs[10] = '{16'h0712, 4'd7,  16'h0000, 1'b1, 1'b0};
        vecs[11] = '{16'hA312, 4'd3,  16'h0008, 1'b1, 1'b1};
        vecs[12] = '{16'h7312, 4'd3,  16'h0008, 1'b1, 1'b0};
        vecs[13] = '{16'h6A80, 4'd10, 16'h0080, 1'b1, 1'b0};
        vecs[14] = '{16'h3815, 4'd8,  16'h0006, 1'b0, 1'b0};
        vecs[15] = '{16'h4942, 4'd9,  16'h0001, 1'b0, 1'b0};
        vecs[16] = '{16'h0052, 4'd0,  16'h0000, 1'b0, 1'b0};
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0000;
        dbg_addr = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_zero", zero_flag, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_ctl", bus.alu_control, 0);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("v%0d_ready", i), bus.instr_ready, 1);
            run(vecs[i].w, lat, ill);
            chk($sformatf("v%0d_latency", i), lat, 3);
            chk($sformatf("v%0d_illegal", i), ill, vecs[i].ill);
            chk($sformatf("v%0d_zero", i), zero_flag, vecs[i].z);
            rd(vecs[i].reg_idx, d);
            chk($sformatf("v%0d_reg", i), d, vecs[i].reg_val);
        end
        // ADD R0,R5,R2 left its operands on the ALU bus.
        chk("hold_alu_a", bus.alu_a, 16'h0006);
        chk("hold_alu_b", bus.alu_b, 16'h0001);
        chk("hold_ctl", bus.alu_control, 4'h0);
        bus.instr_valid = 1'b1;
        bus.instr = 16'h6B11;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.instr_ready) acc++;
        end
        bus.instr_valid = 1'b0;
        chk("busy_accepts", acc, 3);
        lat = 0;
        while (lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        chk("busy_last_done", lat, 1);
        rd(4'd11, d);
        chk("busy_r11", d, 16'h0011);
        @(posedge clk);
        #1;
        chk("busy_no_extra", {done, bus.instr_ready}, 2'b01);
        bus.instr_valid = 1'b1;
        bus.instr = 16'h0352;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_ready", bus.instr_ready, 1);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) acc++;
            @(posedge clk);
            #1;
        end
        chk("mid_rst_no_done", acc, 0);
        rd(4'd3, d);
        chk("mid_rst_r3", d, 16'h0000);
        rd(4'd5, d);
        chk("mid_rst_r5", d, 16'h0000);
        chk("mid_rst_zero", zero_flag, 0);
        chk("mid_rst_alu_a", bus.alu_a, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
